nios_system_sysid_ext: RTL and testbench

Parametrised system-ID/housekeeping Avalon-MM slave for the Nios system. It extends the fixed ID/timestamp responder with several additions:
- a free-running 64-bit uptime counter with prescaler and coherent high-word snapshot
- a software scratch register and a control register
- pipelined fixed-latency reads with readdatavalid

Software uses it to identify the build, check bus integrity and measure elapsed time.

---
 rtl/nios_system_sysid_ext_if.sv | 23 ++
 rtl/nios_system_sysid_ext.sv | 109 ++++++++++
 tb/tb_nios_system_sysid_ext.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM slave bus bundle for the system-ID/housekeeping block.
// The master drives the request; the slave returns fixed-latency read data.
interface nios_system_sysid_ext_if #(
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/nios_system_sysid_ext.sv
// System-ID/housekeeping Avalon-MM slave: build ID, 64-bit uptime with
// prescaler and coherent high-word snapshot, scratch and control registers.
module nios_system_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID    = 32'h583E6817,
  parameter logic [31:0] TIMESTAMP    = 32'h00000000,
  parameter int          ADDR_W       = 3,
  parameter int          READ_LATENCY = 1,
  parameter int          PRESCALE     = 1,
  parameter logic [31:0] SCRATCH_INIT = 32'h00000000
) (
  input  logic                    clock,
  input  logic                    reset,
  nios_system_sysid_ext_if.slave  avs,
  output logic                    tick
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LOAD = PW'(PRESCALE - 1);
  localparam logic [7:0]    CAP_PS   = (PRESCALE > 255) ? 8'd255 : 8'(PRESCALE);
  localparam logic [1:0]    CAP_RL   = 2'(READ_LATENCY);
  localparam logic [31:0]   CAP_WORD = {16'd0, CAP_PS, 4'd0, CAP_RL, 2'b01};

  logic [PW-1:0] pre_left;
  logic [63:0]   uptime;
  logic [31:0]   snap_hi;
  logic [31:0]   scratch;
  logic          freeze;
  logic          wr_ok;
  logic          clr;
  logic          inc;
  logic [31:0]   rd_mux;

  logic [READ_LATENCY-1:0] pipe_v;
  logic [31:0]             pipe_d [READ_LATENCY];

  // A read in the same cycle wins; the write is silently dropped.
  assign wr_ok = avs.write & ~avs.read;
  assign clr   = wr_ok && (avs.address == ADDR_W'(6)) && avs.byteenable[0] && avs.writedata[1];
  // Prescaler counts down to zero; the zero cycle is the increment cycle.
  assign inc   = ~reset & ~freeze & ~clr & (pre_left == '0);
  assign tick  = inc;

  always_comb begin
    rd_mux = '0;
    case (avs.address)
      ADDR_W'(0): rd_mux = SYSTEM_ID;
      ADDR_W'(1): rd_mux = TIMESTAMP;
      ADDR_W'(2): rd_mux = uptime[31:0];
      ADDR_W'(3): rd_mux = snap_hi;
      ADDR_W'(4): rd_mux = scratch;
      ADDR_W'(5): rd_mux = CAP_WORD;
      ADDR_W'(6): rd_mux = {31'd0, freeze};
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_left <= PRE_LOAD;
      uptime   <= '0;
    end else if (clr) begin
      pre_left <= PRE_LOAD;
      uptime   <= '0;
    end else if (!freeze) begin
      if (pre_left == '0) begin
        pre_left <= PRE_LOAD;
        uptime   <= uptime + 64'd1;
      end else begin
        pre_left <= pre_left - PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      snap_hi <= '0;
      scratch <= SCRATCH_INIT;
      freeze  <= 1'b0;
    end else begin
      if (avs.read && avs.address == ADDR_W'(2))
        snap_hi <= uptime[63:32];
      if (wr_ok && avs.address == ADDR_W'(4)) begin
        for (int b = 0; b < 4; b++)
          if (avs.byteenable[b]) scratch[b*8 +: 8] <= avs.writedata[b*8 +: 8];
      end
      if (wr_ok && avs.address == ADDR_W'(6) && avs.byteenable[0])
        freeze <= avs.writedata[0];
    end
  end

  // Response delay line; data is forced to zero on idle slots.
  always_ff @(posedge clock) begin
    if (reset) begin
      pipe_v <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= avs.read;
      pipe_d[0] <= avs.read ? rd_mux : 32'd0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign avs.readdatavalid = pipe_v[READ_LATENCY-1];
  assign avs.readdata      = pipe_d[READ_LATENCY-1];

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Two differently configured instances driven with identical stimulus and
// compared every cycle against a register-map level reference model.
module tb_nios_system_sysid_ext;

  localparam int          P0 = 4,   RL0 = 1;
  localparam int          P1 = 260, RL1 = 2;
  localparam logic [31:0] SID1 = 32'hCAFE0001;
  localparam logic [31:0] TS1  = 32'h60000000;
  localparam logic [31:0] SI1  = 32'hA5A55A5A;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick_a, tick_b;

  nios_system_sysid_ext_if #(.ADDR_W(3)) bus_a ();
  nios_system_sysid_ext_if #(.ADDR_W(4)) bus_b ();

  nios_system_sysid_ext #(
    .ADDR_W(3), .READ_LATENCY(RL0), .PRESCALE(P0)
  ) dut_a (
    .clock(clock), .reset(reset), .avs(bus_a), .tick(tick_a)
  );

  nios_system_sysid_ext #(
    .SYSTEM_ID(SID1), .TIMESTAMP(TS1), .ADDR_W(4), .READ_LATENCY(RL1),
    .PRESCALE(P1), .SCRATCH_INIT(SI1)
  ) dut_b (
    .clock(clock), .reset(reset), .avs(bus_b), .tick(tick_b)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit m_valid  = 1'b0;

  logic [63:0] m_up    [2];
  int          m_phase [2];
  logic [31:0] m_scr   [2];
  logic [31:0] m_snap  [2];
  logic        m_frz   [2];
  logic        m_ev    [2][8];
  logic [31:0] m_ed    [2][8];

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] m_read(input int i, input logic [3:0] a);
    int p, rl, ps;
    p  = (i == 0) ? P0 : P1;
    rl = (i == 0) ? RL0 : RL1;
    ps = (p > 255) ? 255 : p;
    case (a)
      4'd0:    return (i == 0) ? 32'h583E6817 : SID1;
      4'd1:    return (i == 0) ? 32'h00000000 : TS1;
      4'd2:    return m_up[i][31:0];
      4'd3:    return m_snap[i];
      4'd4:    return m_scr[i];
      4'd5:    return 32'(ps * 256 + rl * 4 + 1);
      4'd6:    return {31'd0, m_frz[i]};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_cycle(input int i, input logic rst, input logic rd, input logic wr,
                             input logic [3:0] a_in, input logic [31:0] wd, input logic [3:0] be);
    logic [3:0] a;
    logic       clr, inc, got_t, got_v;
    logic [31:0] got_d;
    int p, rl, slot;
    a     = (i == 0) ? (a_in & 4'h7) : a_in;
    p     = (i == 0) ? P0 : P1;
    rl    = (i == 0) ? RL0 : RL1;
    slot  = cyc % 8;
    clr   = !rst && wr && !rd && a == 4'd6 && be[0] && wd[1];
    inc   = !rst && !m_frz[i] && !clr && (m_phase[i] == p - 1);
    got_t = (i == 0) ? tick_a : tick_b;
    got_v = (i == 0) ? bus_a.readdatavalid : bus_b.readdatavalid;
    got_d = (i == 0) ? bus_a.readdata : bus_b.readdata;
    if (m_valid) begin
      chk_eq($sformatf("tick_%0d", i), 64'(got_t), 64'(inc));
      chk_eq($sformatf("rdv_%0d", i), 64'(got_v), 64'(m_ev[i][slot]));
      chk_eq($sformatf("rdata_%0d", i), 64'(got_d), 64'(m_ed[i][slot]));
    end
    m_ev[i][slot] = 1'b0;
    m_ed[i][slot] = 32'd0;
    if (rst) begin
      m_up[i] = 64'd0; m_phase[i] = 0; m_snap[i] = 32'd0; m_frz[i] = 1'b0;
      m_scr[i] = (i == 0) ? 32'd0 : SI1;
      for (int k = 0; k < 8; k++) begin m_ev[i][k] = 1'b0; m_ed[i][k] = 32'd0; end
    end else begin
      if (rd) begin
        m_ev[i][(cyc + rl) % 8] = 1'b1;
        m_ed[i][(cyc + rl) % 8] = m_read(i, a);
        if (a == 4'd2) m_snap[i] = m_up[i][63:32];
      end
      if (clr) begin
        m_up[i] = 64'd0; m_phase[i] = 0;
      end else if (!m_frz[i]) begin
        if (inc) begin m_phase[i] = 0; m_up[i] = m_up[i] + 64'd1; end
        else m_phase[i] = m_phase[i] + 1;
      end
      if (wr && !rd) begin
        if (a == 4'd4)
          for (int b = 0; b < 4; b++) if (be[b]) m_scr[i][b*8 +: 8] = wd[b*8 +: 8];
        if (a == 4'd6 && be[0]) m_frz[i] = wd[0];
      end
    end
  endtask

  task automatic step(input logic rst, input logic rd, input logic wr, input logic [3:0] a,
                      input logic [31:0] wd, input logic [3:0] be);
    reset = rst;
    bus_a.read = rd; bus_a.write = wr; bus_a.address = a[2:0];
    bus_a.writedata = wd; bus_a.byteenable = be;
    bus_b.read = rd; bus_b.write = wr; bus_b.address = a;
    bus_b.writedata = wd; bus_b.byteenable = be;
    #1;
    model_cycle(0, rst, rd, wr, a, wd, be);
    model_cycle(1, rst, rd, wr, a, wd, be);
    if (rst) m_valid = 1'b1;
    cyc++;
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
  endtask

  task automatic rd_word(input logic [3:0] a);
    step(1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0);
  endtask

  task automatic wr_word(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    step(1'b0, 1'b0, 1'b1, a, d, be);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 8; k++) begin m_ev[i][k] = 1'b0; m_ed[i][k] = 32'd0; end
    bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.address = '0;
    bus_a.writedata = '0; bus_a.byteenable = '0;
    bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.address = '0;
    bus_b.writedata = '0; bus_b.byteenable = '0;
    @(negedge clock);
    step(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0, 32'd0, 4'd0);

    // ID words, unmapped addresses, capability
    rd_word(4'd0); rd_word(4'd1); rd_word(4'd7); rd_word(4'd9); rd_word(4'd5);
    idle(3);

    // scratch byte lanes and RO write protection
    wr_word(4'd4, 32'hDEADBEEF, 4'hF);
    wr_word(4'd4, 32'h00000055, 4'h1);
    rd_word(4'd4);
    wr_word(4'd0, 32'h11111111, 4'hF);
    rd_word(4'd0);
    idle(3);

    // free-running uptime and tick cadence
    idle(30);
    rd_word(4'd2);
    idle(2);

    // freeze, then clear while frozen (bit0 kept set)
    wr_word(4'd6, 32'h1, 4'h1);
    idle(20);
    rd_word(4'd2);
    wr_word(4'd6, 32'h3, 4'h1);
    rd_word(4'd2); rd_word(4'd6);
    idle(2);

    // snapshot coherence across a low-word carry
    force dut_a.uptime = 64'h00000000_FFFFFFFF;
    m_up[0] = 64'h00000000_FFFFFFFF;
    idle(1);
    release dut_a.uptime;
    rd_word(4'd2); rd_word(4'd3);
    wr_word(4'd6, 32'h0, 4'h1);
    idle(10);
    rd_word(4'd2); rd_word(4'd3);
    idle(3);

    // simultaneous read and write: the write is dropped
    step(1'b0, 1'b1, 1'b1, 4'd4, 32'h12345678, 4'hF);
    rd_word(4'd4);
    idle(3);

    // back-to-back reads, then a reset landing in the pipeline
    rd_word(4'd0); rd_word(4'd1); rd_word(4'd4);
    idle(4);
    rd_word(4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd1, 32'd0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd4, 32'd0, 4'd0);
    idle(4);

    for (int n = 0; n < 1500; n++) begin
      logic r, rd, wr;
      logic [3:0] a;
      r  = ($urandom_range(0, 99) == 0);
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 3) == 0);
      a  = 4'($urandom_range(0, 15));
      if (a == 4'd6 && $urandom_range(0, 3) != 0) a = 4'd2;
      step(r, rd, wr, a, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
